// File: rtl/ddr2_aref_pkg.sv
// Shared constants for the DDR2 auto-refresh scheduler.
// DDR2_AREF_POSTPONE_EN selects refresh postponement (PMAX=8) instead of one-per-grant (PMAX=1).
package ddr2_aref_pkg;

    localparam int unsigned TREFI_CYC_DEF = 1560;
    localparam int unsigned TRP_CYC_DEF   = 3;
    localparam int unsigned TRFC_CYC_DEF  = 26;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_PREA  = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_DESEL = 4'b1111;

`ifdef DDR2_AREF_POSTPONE_EN
    localparam int unsigned PMAX   = 8;
    localparam int unsigned PEND_W = 4;
`else
    localparam int unsigned PMAX   = 1;
    localparam int unsigned PEND_W = 1;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StPre,
        StWaitRp,
        StRef,
        StWaitRfc
    } aref_state_e;

endpackage

// File: rtl/ddr2_aref_timer.sv
// Periodic down-counter: one-cycle tick every PERIOD enabled cycles, reloaded while disabled.
module ddr2_aref_timer #(
    parameter int unsigned PERIOD = 1560
) (
    input  logic ck,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned W = $clog2(PERIOD);
    localparam logic [W-1:0] RELOAD = W'(PERIOD - 1);

    logic [W-1:0] count_q;

    always_ff @(posedge ck) begin
        if (!rst_n || !en) begin
            count_q <= RELOAD;
        end else if (count_q == '0) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_q - W'(1);
        end
    end

    assign tick = en && (count_q == '0);

endmodule

// File: rtl/ddr2_aref.sv
// DDR2 auto-refresh scheduler: tREFI pacing, bus req/ack, then PREA + REF with tRP/tRFC spacing.
// DDR2_AREF_POSTPONE_EN enables postponed refreshes issued as a back-to-back REF burst.
`ifndef BA_BITS
`define BA_BITS 3
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif

module ddr2_aref
    import ddr2_aref_pkg::*;
#(
    parameter int unsigned TREFI_CYC = TREFI_CYC_DEF,
    parameter int unsigned TRP_CYC   = TRP_CYC_DEF,
    parameter int unsigned TRFC_CYC  = TRFC_CYC_DEF
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic                  init_done,
    output logic                  ref_req,
    input  logic                  ref_ack,
    output logic                  ref_busy,
    output logic                  ref_done,
    output logic                  ref_overflow,
    output logic                  cmd_cs_n,
    output logic                  cmd_ras_n,
    output logic                  cmd_cas_n,
    output logic                  cmd_we_n,
    output logic [`BA_BITS-1:0]   cmd_ba,
    output logic [`ADDR_BITS-1:0] cmd_addr
);

    localparam int unsigned CNT_MAX = (TRFC_CYC > TRP_CYC) ? TRFC_CYC : TRP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);
    localparam logic [`ADDR_BITS-1:0] ADDR_A10 = `ADDR_BITS'(1 << 10);

    aref_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pending_q, pending_d;
    logic              overflow_d;
    logic              tick, issue, burst, done_d;
    logic [3:0]        cmd_d;

    ddr2_aref_timer #(
        .PERIOD (TREFI_CYC)
    ) u_timer (
        .ck    (ck),
        .rst_n (rst_n),
        .en    (init_done),
        .tick  (tick)
    );

    // The REF command is on the pins for exactly the cycle spent in StRef.
    assign issue = (state_q == StRef);

`ifdef DDR2_AREF_POSTPONE_EN
    assign burst = (pending_q != '0);
`else
    assign burst = 1'b0;
`endif

    always_comb begin
        pending_d  = pending_q;
        overflow_d = ref_overflow;
        if (tick && !issue) begin
            if (pending_q == PEND_W'(PMAX)) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (issue && !tick) begin
            pending_d = pending_q - PEND_W'(1);
        end
        if (!init_done) begin
            pending_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        unique case (state_q)
            StIdle:    if (pending_q != '0) state_d = StReq;
            StReq:     if (ref_ack) state_d = StPre;
            StPre: begin
                state_d = StWaitRp;
                cnt_d   = CNT_W'(TRP_CYC - 2);
            end
            StWaitRp:  if (cnt_q == '0) state_d = StRef;
            StRef: begin
                state_d = StWaitRfc;
                cnt_d   = CNT_W'(TRFC_CYC - 2);
            end
            StWaitRfc: begin
                if (cnt_q == '0) begin
                    if (burst) begin
                        state_d = StRef;
                    end else begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default:   state_d = StIdle;
        endcase
        if (!init_done) begin
            state_d = StIdle;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        cmd_d = CMD_NOP;
        if (!init_done) begin
            cmd_d = CMD_DESEL;
        end else if (state_d == StPre) begin
            cmd_d = CMD_PREA;
        end else if (state_d == StRef) begin
            cmd_d = CMD_REF;
        end
    end

    always_ff @(posedge ck) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            pending_q    <= '0;
            ref_overflow <= 1'b0;
            ref_req      <= 1'b0;
            ref_busy     <= 1'b0;
            ref_done     <= 1'b0;
            {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} <= CMD_DESEL;
            cmd_ba       <= '0;
            cmd_addr     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            ref_overflow <= overflow_d;
            ref_req      <= (state_d == StReq);
            ref_busy     <= (state_d == StPre) || (state_d == StWaitRp) ||
                            (state_d == StRef) || (state_d == StWaitRfc);
            ref_done     <= done_d;
            {cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n} <= cmd_d;
            cmd_ba       <= '0;
            cmd_addr     <= (cmd_d == CMD_PREA) ? ADDR_A10 : '0;
        end
    end

endmodule
